// File: rtl/ctrl_pkg.sv
// ---------------------------------------------------------------------------
// ctrl_pkg
// Shared definitions for the camera capture sequencer:
//   - state_t         : 3-bit state encoding of the capture FSM
//   - EX_*_DEFAULT    : default exposure width / limits
//   - clamp_exposure  : limits a requested exposure to [lo, hi]
// ---------------------------------------------------------------------------
package ctrl_pkg;

  localparam int EX_W_DEFAULT   = 5;
  localparam int EX_MIN_DEFAULT = 2;
  localparam int EX_MAX_DEFAULT = 30;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_EXPOSE  = 3'd1,
    ST_R1_SEL  = 3'd2,
    ST_R1_CONV = 3'd3,
    ST_R1_GAP  = 3'd4,
    ST_R2_SEL  = 3'd5,
    ST_R2_CONV = 3'd6,
    ST_R2_GAP  = 3'd7
  } state_t;

  // The requested value arrives zero-extended from the register width, so
  // this is effectively an unsigned compare at that width.
  function automatic int clamp_exposure(input int ex, input int lo, input int hi);
    int result;
    result = ex;
    if (ex < lo) begin
      result = lo;
    end else if (ex > hi) begin
      result = hi;
    end
    return result;
  endfunction

endpackage

// File: rtl/ctrl_cycle_timer.sv
// ---------------------------------------------------------------------------
// ctrl_cycle_timer
// Loadable down-counter used to time every multi-cycle phase of a capture.
// Ports:
//   clk        : clock
//   rst_n      : asynchronous active-low reset, clears the count
//   load       : load load_value this cycle (takes priority over counting)
//   load_value : number of cycles the phase should last (>= 1)
//   done       : high while the count is 1, i.e. the last cycle of the phase
// ---------------------------------------------------------------------------
module ctrl_cycle_timer #(
  parameter int W = 5
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic [W-1:0] load_value,
  output logic         done
);

  logic [W-1:0] count;

  // Counts down to zero and parks there until the next load.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (load) begin
      count <= load_value;
    end else if (count != '0) begin
      count <= count - W'(1);
    end
  end

  assign done = (count == W'(1));

endmodule

// File: rtl/ctrl_capture_seq.sv
// ---------------------------------------------------------------------------
// ctrl_capture_seq
// Capture sequencer for the camera pixel array. On a capture request it
// latches the clamped exposure length and walks the array through
// Erase -> Expose -> row-1 readout -> row-2 readout, strobing the ADC during
// each row conversion, then returns to IDLE with a one-cycle Frame_done.
// Ports:
//   Clk        : system clock
//   Reset_n    : asynchronous active-low reset
//   Init       : capture request, level-sampled, honoured only in IDLE
//   EX_time    : requested exposure length in cycles
//   Erase      : pixel erase, high in IDLE
//   Expose     : pixel exposure enable
//   NRE_1      : row-1 read enable, active low
//   NRE_2      : row-2 read enable, active low
//   ADC        : ADC conversion strobe
//   Exp_lock   : freezes the exposure-time register while a frame runs
//   Busy       : high in every state except IDLE
//   Frame_done : one-cycle pulse in the first IDLE cycle after readout
// All outputs are registered.
// ---------------------------------------------------------------------------
module ctrl_capture_seq
  import ctrl_pkg::*;
#(
  parameter int EX_W          = EX_W_DEFAULT,
  parameter int EX_MIN        = EX_MIN_DEFAULT,
  parameter int EX_MAX        = EX_MAX_DEFAULT,
  parameter int SETTLE_CYCLES = 1,
  parameter int ADC_CYCLES    = 1
) (
  input  logic            Clk,
  input  logic            Reset_n,
  input  logic            Init,
  input  logic [EX_W-1:0] EX_time,
  output logic            Erase,
  output logic            Expose,
  output logic            NRE_1,
  output logic            NRE_2,
  output logic            ADC,
  output logic            Exp_lock,
  output logic            Busy,
  output logic            Frame_done
);

  // The timer must hold the longest exposure and the 3-bit settle/ADC counts.
  localparam int EX_BITS = $clog2(EX_MAX + 1);
  localparam int CNT_W   = (EX_BITS > 3) ? EX_BITS : 3;

  localparam logic [CNT_W-1:0] SETTLE_LOAD = CNT_W'(SETTLE_CYCLES);
  localparam logic [CNT_W-1:0] ADC_LOAD    = CNT_W'(ADC_CYCLES);

  state_t           state;
  logic             timer_load;
  logic [CNT_W-1:0] timer_value;
  logic             timer_done;
  logic [CNT_W-1:0] exposure_load;

  // EX_time is only sampled on the accepting edge; later changes are ignored
  // because the timer already holds the latched length.
  assign exposure_load = CNT_W'(clamp_exposure(int'({{(32-EX_W){1'b0}}, EX_time}),
                                               EX_MIN, EX_MAX));

  // Phase timer loads: each multi-cycle phase is loaded on the edge that
  // enters it. The gap states are fixed at one cycle and need no timer.
  always_comb begin
    timer_load  = 1'b0;
    timer_value = '0;
    case (state)
      ST_IDLE: begin
        if (Init) begin
          timer_load  = 1'b1;
          timer_value = exposure_load;
        end
      end
      ST_EXPOSE: begin
        if (timer_done) begin
          timer_load  = 1'b1;
          timer_value = SETTLE_LOAD;
        end
      end
      ST_R1_SEL, ST_R2_SEL: begin
        if (timer_done) begin
          timer_load  = 1'b1;
          timer_value = ADC_LOAD;
        end
      end
      ST_R1_GAP: begin
        timer_load  = 1'b1;
        timer_value = SETTLE_LOAD;
      end
      default: begin
        timer_load  = 1'b0;
        timer_value = '0;
      end
    endcase
  end

  ctrl_cycle_timer #(
    .W(CNT_W)
  ) u_timer (
    .clk       (Clk),
    .rst_n     (Reset_n),
    .load      (timer_load),
    .load_value(timer_value),
    .done      (timer_done)
  );

  // Capture FSM. Outputs are assigned on the transition into the state that
  // owns them, so every output is a flop and changes only on a clock edge.
  // Frame_done defaults low each cycle and is raised only when leaving R2_GAP.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state      <= ST_IDLE;
      Erase      <= 1'b1;
      Expose     <= 1'b0;
      NRE_1      <= 1'b1;
      NRE_2      <= 1'b1;
      ADC        <= 1'b0;
      Exp_lock   <= 1'b0;
      Busy       <= 1'b0;
      Frame_done <= 1'b0;
    end else begin
      Frame_done <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (Init) begin
            state    <= ST_EXPOSE;
            Erase    <= 1'b0;
            Expose   <= 1'b1;
            Exp_lock <= 1'b1;
            Busy     <= 1'b1;
          end
        end
        ST_EXPOSE: begin
          if (timer_done) begin
            state  <= ST_R1_SEL;
            Expose <= 1'b0;
            NRE_1  <= 1'b0;
          end
        end
        ST_R1_SEL: begin
          if (timer_done) begin
            state <= ST_R1_CONV;
            ADC   <= 1'b1;
          end
        end
        ST_R1_CONV: begin
          if (timer_done) begin
            state <= ST_R1_GAP;
            ADC   <= 1'b0;
            NRE_1 <= 1'b1;
          end
        end
        ST_R1_GAP: begin
          state <= ST_R2_SEL;
          NRE_2 <= 1'b0;
        end
        ST_R2_SEL: begin
          if (timer_done) begin
            state <= ST_R2_CONV;
            ADC   <= 1'b1;
          end
        end
        ST_R2_CONV: begin
          if (timer_done) begin
            state <= ST_R2_GAP;
            ADC   <= 1'b0;
            NRE_2 <= 1'b1;
          end
        end
        ST_R2_GAP: begin
          state      <= ST_IDLE;
          Erase      <= 1'b1;
          Exp_lock   <= 1'b0;
          Busy       <= 1'b0;
          Frame_done <= 1'b1;
        end
        default: begin
          state    <= ST_IDLE;
          Erase    <= 1'b1;
          Expose   <= 1'b0;
          NRE_1    <= 1'b1;
          NRE_2    <= 1'b1;
          ADC      <= 1'b0;
          Exp_lock <= 1'b0;
          Busy     <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ctrl_capture_seq.sv
// ---------------------------------------------------------------------------
// tb_ctrl_capture_seq
// Self-checking bench for ctrl_capture_seq. A frame-level reference model
// tracks whether a frame is running and how many cycles into it we are, and
// derives every expected output from the phase lengths with plain arithmetic.
// ---------------------------------------------------------------------------
module tb_ctrl_capture_seq;

  localparam int EX_W   = 5;
  localparam int EX_MIN = 2;
  localparam int EX_MAX = 30;
  localparam int S      = 1;
  localparam int A      = 1;
  localparam int ROW_LEN = S + A + 1;

  logic            Clk = 1'b0;
  logic            Reset_n;
  logic            Init;
  logic [EX_W-1:0] EX_time;
  logic            Erase, Expose, NRE_1, NRE_2, ADC, Exp_lock, Busy, Frame_done;

  int checks   = 0;
  int failures = 0;
  bit mon_en   = 1'b0;

  ctrl_capture_seq #(
    .EX_W         (EX_W),
    .EX_MIN       (EX_MIN),
    .EX_MAX       (EX_MAX),
    .SETTLE_CYCLES(S),
    .ADC_CYCLES   (A)
  ) dut (
    .Clk       (Clk),
    .Reset_n   (Reset_n),
    .Init      (Init),
    .EX_time   (EX_time),
    .Erase     (Erase),
    .Expose    (Expose),
    .NRE_1     (NRE_1),
    .NRE_2     (NRE_2),
    .ADC       (ADC),
    .Exp_lock  (Exp_lock),
    .Busy      (Busy),
    .Frame_done(Frame_done)
  );

  always #5 Clk = ~Clk;

  wire [7:0] obs = {Erase, Expose, NRE_1, NRE_2, ADC, Exp_lock, Busy, Frame_done};

  // Reference model: frame-level view of the sequencer.
  bit m_active = 1'b0;
  bit m_done   = 1'b0;
  int m_k      = 0;
  int m_n      = 0;

  function automatic int ref_n(input int ex);
    if (ex < EX_MIN) return EX_MIN;
    if (ex > EX_MAX) return EX_MAX;
    return ex;
  endfunction

  function automatic int frame_len(input int n);
    return n + 2 * ROW_LEN;
  endfunction

  always @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      m_active <= 1'b0;
      m_done   <= 1'b0;
      m_k      <= 0;
      m_n      <= 0;
    end else if (!m_active) begin
      m_done <= 1'b0;
      if (Init === 1'b1) begin
        m_active <= 1'b1;
        m_k      <= 0;
        m_n      <= ref_n(int'(EX_time));
      end
    end else begin
      m_done <= 1'b0;
      if (m_k == frame_len(m_n) - 1) begin
        m_active <= 1'b0;
        m_done   <= 1'b1;
      end else begin
        m_k <= m_k + 1;
      end
    end
  end

  // Expected {Erase,Expose,NRE_1,NRE_2,ADC,Exp_lock,Busy,Frame_done}.
  function automatic logic [7:0] model_vec();
    logic erase, expose, nre1, nre2, adc, busy;
    int r, row, ph;
    erase = 1'b1; expose = 1'b0; nre1 = 1'b1; nre2 = 1'b1; adc = 1'b0; busy = 1'b0;
    if (m_active) begin
      erase = 1'b0;
      busy  = 1'b1;
      if (m_k < m_n) begin
        expose = 1'b1;
      end else begin
        r   = m_k - m_n;
        row = r / ROW_LEN;
        ph  = r % ROW_LEN;
        if (ph < S + A) begin
          if (row == 0) nre1 = 1'b0;
          else          nre2 = 1'b0;
          adc = (ph >= S);
        end
      end
    end
    return {erase, expose, nre1, nre2, adc, busy, busy, m_done};
  endfunction

  // Structural invariants, checked every cycle out of reset.
  always @(negedge Clk) begin
    if (mon_en && Reset_n === 1'b1) begin
      checks++;
      if (NRE_1 === 1'b0 && NRE_2 === 1'b0) begin
        failures++;
        $display("[TB] FAIL inv_nre_excl: NRE_1=%b NRE_2=%b, both must not be low", NRE_1, NRE_2);
      end
      checks++;
      if (Expose === 1'b1 && Erase === 1'b1) begin
        failures++;
        $display("[TB] FAIL inv_expose_erase: Expose=%b Erase=%b, not both high", Expose, Erase);
      end
      checks++;
      if (ADC === 1'b1 && (NRE_1 ^ NRE_2) !== 1'b1) begin
        failures++;
        $display("[TB] FAIL inv_adc_row: ADC=1 with NRE_1=%b NRE_2=%b, need exactly one low", NRE_1, NRE_2);
      end
    end
  end

  task automatic test_reset();
    Reset_n = 1'b0;
    Init    = 1'b0;
    EX_time = '0;
    repeat (3) @(negedge Clk);
    checks++;
    if (obs !== 8'hB0) begin
      failures++;
      $display("[TB] FAIL reset_values: got %b, want %b", obs, 8'hB0);
    end
    Reset_n = 1'b1;
    mon_en  = 1'b1;
    @(negedge Clk);
    checks++;
    if (obs !== model_vec()) begin
      failures++;
      $display("[TB] FAIL reset_release_idle: got %b, want %b", obs, model_vec());
    end
  endtask

  task automatic test_nominal();
    int expose_cnt = 0;
    int fd_cycle   = -1;
    EX_time = 5'd10;
    Init    = 1'b1;
    for (int c = 1; c <= 20; c++) begin
      @(negedge Clk);
      Init = 1'b0;
      checks++;
      if (obs !== model_vec()) begin
        failures++;
        $display("[TB] FAIL nominal_cycle%0d: got %b, want %b", c, obs, model_vec());
      end
      if (Expose === 1'b1) expose_cnt++;
      if (Frame_done === 1'b1 && fd_cycle < 0) fd_cycle = c;
    end
    checks++;
    if (expose_cnt != 10) begin
      failures++;
      $display("[TB] FAIL nominal_expose_len: got %0d, want 10", expose_cnt);
    end
    checks++;
    if (fd_cycle != 17) begin
      failures++;
      $display("[TB] FAIL nominal_frame_len: got %0d, want 17", fd_cycle);
    end
  endtask

  task automatic test_clamp();
    logic [EX_W-1:0] vals [6];
    vals = '{5'd0, 5'd1, 5'd31, 5'd2, 5'd30, 5'd17};
    for (int i = 0; i < 6; i++) begin
      int expose_cnt = 0;
      int fd_cnt = 0;
      int want = ref_n(int'(vals[i]));
      EX_time = vals[i];
      Init    = 1'b1;
      for (int c = 1; c <= frame_len(want) + 2; c++) begin
        @(negedge Clk);
        Init    = 1'b0;
        EX_time = 5'($urandom_range(0, 31));
        checks++;
        if (obs !== model_vec()) begin
          failures++;
          $display("[TB] FAIL clamp_ex%0d_cycle%0d: got %b, want %b", vals[i], c, obs, model_vec());
        end
        if (Expose === 1'b1) expose_cnt++;
        if (Frame_done === 1'b1) fd_cnt++;
      end
      checks++;
      if (expose_cnt != want || fd_cnt != 1) begin
        failures++;
        $display("[TB] FAIL clamp_ex%0d: expose=%0d done=%0d, want expose=%0d done=1",
                 vals[i], expose_cnt, fd_cnt, want);
      end
    end
  endtask

  task automatic test_ex_change_and_init_ignored();
    int expose_cnt = 0;
    int lock_cnt   = 0;
    int fd_cnt     = 0;
    EX_time = 5'd10;
    Init    = 1'b1;
    for (int c = 1; c <= 20; c++) begin
      @(negedge Clk);
      checks++;
      if (obs !== model_vec()) begin
        failures++;
        $display("[TB] FAIL freeze_cycle%0d: got %b, want %b", c, obs, model_vec());
      end
      if (Expose === 1'b1) expose_cnt++;
      if (Exp_lock === 1'b1) lock_cnt++;
      if (Frame_done === 1'b1) fd_cnt++;
      Init = (c >= 11 && c <= 14) ? c[0] : 1'b0;
      if (c == 3) EX_time = 5'd4;
    end
    checks++;
    if (expose_cnt != 10 || lock_cnt != 16 || fd_cnt != 1) begin
      failures++;
      $display("[TB] FAIL freeze_summary: expose=%0d lock=%0d done=%0d, want 10 16 1",
               expose_cnt, lock_cnt, fd_cnt);
    end
  endtask

  task automatic test_back_to_back();
    int fd_cnt   = 0;
    int idle_cnt = 0;
    int budget   = 0;
    Init = 1'b1;
    EX_time = 5'($urandom_range(0, 31));
    while (fd_cnt < 3 && budget < 200) begin
      @(negedge Clk);
      budget++;
      checks++;
      if (obs !== model_vec()) begin
        failures++;
        $display("[TB] FAIL b2b_cycle%0d: got %b, want %b", budget, obs, model_vec());
      end
      if (Busy === 1'b0) idle_cnt++;
      if (Frame_done === 1'b1) begin
        fd_cnt++;
        checks++;
        if (Erase !== 1'b1) begin
          failures++;
          $display("[TB] FAIL b2b_gap_erase: got %b, want 1", Erase);
        end
      end
      EX_time = 5'($urandom_range(0, 31));
    end
    Init = 1'b0;
    checks++;
    if (fd_cnt != 3 || idle_cnt != 3) begin
      failures++;
      $display("[TB] FAIL b2b_gaps: frames=%0d idle=%0d, want 3 3", fd_cnt, idle_cnt);
    end
    repeat (2) @(negedge Clk);
  endtask

  task automatic test_reset_abort();
    int fd_cnt = 0;
    int want;
    EX_time = 5'd3;
    Init    = 1'b1;
    for (int c = 1; c <= 5; c++) begin
      @(negedge Clk);
      Init = 1'b0;
      checks++;
      if (obs !== model_vec()) begin
        failures++;
        $display("[TB] FAIL abort_pre_cycle%0d: got %b, want %b", c, obs, model_vec());
      end
    end
    checks++;
    if (ADC !== 1'b1 || NRE_1 !== 1'b0) begin
      failures++;
      $display("[TB] FAIL abort_in_conv: ADC=%b NRE_1=%b, want 1 0", ADC, NRE_1);
    end
    #2 Reset_n = 1'b0;
    #1;
    checks++;
    if (obs !== 8'hB0) begin
      failures++;
      $display("[TB] FAIL abort_immediate: got %b, want %b", obs, 8'hB0);
    end
    repeat (2) @(negedge Clk);
    Reset_n = 1'b1;
    for (int c = 1; c <= 4; c++) begin
      @(negedge Clk);
      checks++;
      if (obs !== model_vec() || Frame_done !== 1'b0) begin
        failures++;
        $display("[TB] FAIL abort_idle_cycle%0d: got %b, want %b", c, obs, model_vec());
      end
    end
    EX_time = 5'($urandom_range(0, 31));
    want    = ref_n(int'(EX_time));
    Init    = 1'b1;
    for (int c = 1; c <= frame_len(want) + 2; c++) begin
      @(negedge Clk);
      Init = 1'b0;
      checks++;
      if (obs !== model_vec()) begin
        failures++;
        $display("[TB] FAIL abort_next_cycle%0d: got %b, want %b", c, obs, model_vec());
      end
      if (Frame_done === 1'b1) fd_cnt++;
    end
    checks++;
    if (fd_cnt != 1) begin
      failures++;
      $display("[TB] FAIL abort_next_frame: done=%0d, want 1", fd_cnt);
    end
  endtask

  task automatic test_random();
    for (int c = 1; c <= 600; c++) begin
      @(negedge Clk);
      checks++;
      if (obs !== model_vec()) begin
        failures++;
        $display("[TB] FAIL random_cycle%0d: got %b, want %b", c, obs, model_vec());
      end
      Init    = ($urandom_range(0, 3) == 0);
      EX_time = 5'($urandom_range(0, 31));
    end
    Init = 1'b0;
  endtask

  initial begin
    test_reset();
    test_nominal();
    test_clamp();
    test_ex_change_and_init_ignored();
    test_back_to_back();
    test_reset_abort();
    test_random();
    repeat (2) @(negedge Clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
